// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks SR1 select through every register and offers
// each captured word to a consumer over a valid/ready handshake.
module regfile_dump_reader #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [2:0]        sr_sel,
  input  logic [DATA_W-1:0] sr_data,
  output logic [DATA_W-1:0] dump_data,
  output logic [2:0]        dump_idx,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CAPT,
    S_SEND,
    S_FINISH
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  idx;
  logic        launch;
  logic        accept;
  logic        is_last;

  assign launch  = (state == S_IDLE) && start && !abort;
  assign accept  = dump_valid && dump_ready;
  assign is_last = (idx == LAST_IDX);

  // NOTE: every output of this block gets a default before the case, so no latches.
  always_comb begin
    state_nxt  = state;
    dump_valid = (state == S_SEND);
    busy       = (state != S_IDLE);
    done       = (state == S_FINISH);
    case (state)
      S_IDLE:   if (launch) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_CAPT;
      S_CAPT:   state_nxt = S_SEND;
      S_SEND:   if (accept) state_nxt = is_last ? S_FINISH : S_SETUP;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    // Abort overrides everything outside IDLE, including a same-cycle acceptance.
    if (abort && state != S_IDLE) state_nxt = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      sr_sel    <= '0;
      dump_data <= '0;
      dump_idx  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE:  if (launch) idx <= '0;
        S_SETUP: sr_sel <= idx;
        S_CAPT: begin
          dump_data <= sr_data;
          dump_idx  <= idx;
        end
        // Index saturates at the last register; FINISH follows instead of a wrap.
        S_SEND:  if (accept && !is_last && !abort) idx <= idx + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a behavioural register file feeds
// SR_data, and each dump is compared with the words the register contents imply.
module tb_regfile_dump_reader;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;
  localparam int BUDGET   = 300;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [2:0]        sr_sel;
  logic [DATA_W-1:0] sr_data;
  logic [DATA_W-1:0] dump_data;
  logic [2:0]        dump_idx;
  logic              dump_valid;
  logic              dump_ready;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] seen [NUM_REGS];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign sr_data = regs[sr_sel];

  regfile_dump_reader #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .sr_sel     (sr_sel),
    .sr_data    (sr_data),
    .dump_data  (dump_data),
    .dump_idx   (dump_idx),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = 16'h1000 + DATA_W'(i);
  endtask

  // Drives one dump starting now (start high in cycle 0) and follows it until the
  // block is idle again. Expected words come from the register array as it stood
  // before each word was first offered; writes during a word's own offer are too late.
  task automatic run_dump(
    input  int          stall_pct,
    input  int          stall_idx,
    input  int          stall_len,
    input  int          abort_idx,
    input  bit          repulse,
    input  bit          rand_writes,
    input  int          wr_at_idx,
    input  int          wr_reg,
    input  logic [15:0] wr_val,
    output int          words,
    output int          dones,
    output int          done_cycle,
    output int          first_valid,
    output int          stalls
  );
    int          cyc;
    int          k;
    int          stalled;
    bit          first;
    logic [15:0] exp_word;
    words = 0; dones = 0; done_cycle = -1; first_valid = -1; stalls = 0;
    k = 0; stalled = 0; first = 1'b1; exp_word = '0;
    start = 1'b1; abort = 1'b0; dump_ready = 1'b0;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < BUDGET) begin
      dump_ready = 1'b0;
      abort      = 1'b0;
      start      = repulse && busy && (cyc % 5 == 2);
      if (done) begin
        dones++;
        done_cycle = cyc;
      end
      if (dump_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (first) begin
          exp_word = regs[k];
          first    = 1'b0;
          if (k == wr_at_idx) regs[wr_reg] = wr_val;
        end
        n_checks++;
        if (dump_idx !== 3'(k) || dump_data !== exp_word) begin
          n_fail++;
          $display("FAIL word: idx=%0d data=%h, required idx=%0d data=%h (cycle %0d)",
                   dump_idx, dump_data, k, exp_word, cyc);
        end
        if (k < NUM_REGS) seen[k] = dump_data;
        if (k == stall_idx && stalled < stall_len) begin
          stalled++;
          stalls++;
        end else if (int'($urandom_range(99)) < stall_pct) begin
          stalls++;
        end else begin
          dump_ready = 1'b1;
        end
        if (k == abort_idx) abort = 1'b1;
        if (rand_writes && $urandom_range(1) == 1) regs[$urandom_range(NUM_REGS-1)] = 16'($urandom);
        if (dump_ready) begin
          words++;
          k++;
          first = 1'b1;
        end
      end
      if (!busy) break;
      step();
      cyc++;
    end
    start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
    n_checks++;
    if (cyc >= BUDGET) begin
      n_fail++;
      $display("FAIL budget: dump still busy after %0d cycles, required idle", cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; abort = 1'b0; dump_ready = 1'b1;
    step(); step();
    n_checks++;
    if ({sr_sel, dump_data, dump_idx, dump_valid, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset: sel=%0d data=%h idx=%0d valid=%b busy=%b done=%b, required all 0",
               sr_sel, dump_data, dump_idx, dump_valid, busy, done);
    end
    reset = 1'b0; start = 1'b0; dump_ready = 1'b0;
    step();
  endtask

  task automatic test_full_dump();
    int w, d, dc, fv, s;
    preload();
    run_dump(0, -1, 0, -1, 1'b0, 1'b0, -1, 0, '0, w, d, dc, fv, s);
    n_checks++;
    if (w != 8 || d != 1) begin
      n_fail++;
      $display("FAIL full_count: words=%0d dones=%0d, required 8 and 1", w, d);
    end
    n_checks++;
    if (fv != 3 || dc != 25) begin
      n_fail++;
      $display("FAIL full_timing: first valid=%0d done=%0d, required 3 and 25", fv, dc);
    end
  endtask

  task automatic test_stall();
    int w, d, dc, fv, s;
    preload();
    run_dump(0, 3, 5, -1, 1'b0, 1'b0, -1, 0, '0, w, d, dc, fv, s);
    n_checks++;
    if (w != 8 || d != 1 || dc != 30 || s != 5) begin
      n_fail++;
      $display("FAIL stall: words=%0d dones=%0d done=%0d stalls=%0d, required 8 1 30 5", w, d, dc, s);
    end
    n_checks++;
    if (seen[3] !== 16'h1003) begin
      n_fail++;
      $display("FAIL stall_word: idx3=%h, required 1003", seen[3]);
    end
  endtask

  task automatic test_abort(input bit with_accept);
    int w, d, dc, fv, s;
    preload();
    run_dump(0, with_accept ? -1 : 4, with_accept ? 0 : 100, 4, 1'b0, 1'b0, -1, 0, '0,
             w, d, dc, fv, s);
    n_checks++;
    if (w != (with_accept ? 5 : 4) || d != 0 || busy !== 1'b0 || dump_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort(acc=%0d): words=%0d dones=%0d busy=%b valid=%b, required %0d 0 0 0",
               with_accept, w, d, busy, dump_valid, with_accept ? 5 : 4);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || dump_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet: busy=%b done=%b valid=%b, required 0 0 0", busy, done, dump_valid);
      end
    end
  endtask

  task automatic test_restart_ignored();
    int w, d, dc, fv, s;
    preload();
    run_dump(0, -1, 0, -1, 1'b1, 1'b0, -1, 0, '0, w, d, dc, fv, s);
    n_checks++;
    if (w != 8 || d != 1 || dc != 25) begin
      n_fail++;
      $display("FAIL restart: words=%0d dones=%0d done=%0d, required 8 1 25", w, d, dc);
    end
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_queued: busy=%b after dump, required 0", busy);
    end
  endtask

  task automatic test_abort_start_idle();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_start: busy=%b, required 0", busy);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_dump();
    int w, d, dc, fv, s;
    int guard;
    bit saw_done;
    preload();
    start = 1'b1; dump_ready = 1'b1;
    step();
    start = 1'b0;
    guard = 0; saw_done = 1'b0;
    while (!(dump_valid && dump_idx == 3'd2) && guard < 50) begin
      step();
      guard++;
    end
    n_checks++;
    if (guard >= 50) begin
      n_fail++;
      $display("FAIL reset_mid_reach: idx 2 not offered within %0d cycles", guard);
    end
    dump_ready = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({sr_sel, dump_data, dump_idx, dump_valid, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: sel=%0d data=%h idx=%0d valid=%b busy=%b done=%b, required all 0",
               sr_sel, dump_data, dump_idx, dump_valid, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_mid_done: done=1 after reset, required 0");
    end
    run_dump(0, -1, 0, -1, 1'b0, 1'b0, -1, 0, '0, w, d, dc, fv, s);
    n_checks++;
    if (w != 8 || d != 1) begin
      n_fail++;
      $display("FAIL reset_restart: words=%0d dones=%0d, required 8 1", w, d);
    end
  endtask

  task automatic test_write_during_dump();
    int w, d, dc, fv, s;
    preload();
    run_dump(0, -1, 0, -1, 1'b0, 1'b0, 3, 5, 16'hBEEF, w, d, dc, fv, s);
    n_checks++;
    if (seen[5] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL write_before_capt: idx5=%h, required beef", seen[5]);
    end
    preload();
    run_dump(0, -1, 0, -1, 1'b0, 1'b0, 2, 2, 16'hDEAD, w, d, dc, fv, s);
    n_checks++;
    if (seen[2] !== 16'h1002) begin
      n_fail++;
      $display("FAIL write_after_capt: idx2=%h, required 1002", seen[2]);
    end
  endtask

  task automatic test_random();
    int w, d, dc, fv, s;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] = 16'($urandom);
      run_dump(40, -1, 0, -1, 1'b0, 1'b1, -1, 0, '0, w, d, dc, fv, s);
      n_checks++;
      if (w != 8 || d != 1 || fv != 3 || dc != 3 * NUM_REGS + 1 + s) begin
        n_fail++;
        $display("FAIL random[%0d]: words=%0d dones=%0d first=%0d done=%0d, required 8 1 3 %0d",
                 it, w, d, fv, dc, 3 * NUM_REGS + 1 + s);
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs[i] = '0;
      seen[i] = '0;
    end
    test_reset();
    test_full_dump();
    test_stall();
    test_abort(1'b0);
    test_abort(1'b1);
    test_restart_ignored();
    test_abort_start_idle();
    test_reset_mid_dump();
    test_write_during_dump();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
